// File: rtl/keypad_loader.sv
// keypad_loader: collects MM:SS BCD digits from the keypad, parallel-loads the
// timer digit counters, gates the 1 Hz count enable and reports completion.
module keypad_loader #(
    parameter int unsigned NDIG = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       start,
    input  logic       cancel,
    input  logic       tick,
    input  logic       timer_zero,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       loadn,
    output logic       en,
    output logic       running,
    output logic       done
);

    localparam int unsigned DIG_W = 4;
    localparam int unsigned CNT_W = 3;
    localparam logic [DIG_W-1:0] MAX_DIGIT  = DIG_W'(9);
    localparam logic [DIG_W-1:0] MAX_STENS  = DIG_W'(5);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NDIG);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4
    } state_e;

    // Entry register: index 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens
    typedef logic [NDIG-1:0][DIG_W-1:0] digits_t;

    state_e           state_q, state_d;
    digits_t          dig_q, dig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             loadn_q, loadn_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic key_ok;
    logic start_ok;

    assign key_ok   = key_valid && (key <= MAX_DIGIT);
    assign start_ok = (dig_q[1] <= MAX_STENS) && (dig_q != '0);

    // State, entry register and registered strobes
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= ST_IDLE;
            dig_q     <= '0;
            cnt_q     <= '0;
            loadn_q   <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dig_q     <= dig_d;
            cnt_q     <= cnt_d;
            loadn_q   <= loadn_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // Next-state, entry register update and next values of registered strobes
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (key_ok) begin
                    dig_d    = '0;
                    dig_d[0] = key;
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (cancel) begin
                    dig_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (start) begin
                    // Any key arriving with start is dropped, accepted or not
                    if (start_ok) begin
                        state_d = ST_LOAD;
                    end
                end else if (key_ok && (cnt_q < FULL_COUNT)) begin
                    dig_d = {dig_q[NDIG-2:0], key};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Completion wins over a simultaneous cancel
                if (timer_zero) begin
                    done_d  = 1'b1;
                    dig_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cancel) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (cancel) begin
                    dig_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                dig_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        loadn_d   = (state_d != ST_LOAD);
        running_d = (state_d == ST_RUN);
    end

    // Count enable: only in RUN, and never once the chain reads 00:00
    always_comb begin
        en = 1'b0;
        if ((state_q == ST_RUN) && tick && !timer_zero) begin
            en = 1'b1;
        end
    end

    assign sec_ones = dig_q[0];
    assign sec_tens = dig_q[1];
    assign min_ones = dig_q[2];
    assign min_tens = dig_q[3];
    assign loadn    = loadn_q;
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: tb/tb_keypad_loader.sv
// Directed bench for keypad_loader with a behavioural seconds-counter model
// standing in for the down-counting digit chain.
module tb_keypad_loader;

    logic       clk;
    logic       clrn;
    logic [3:0] key;
    logic       key_valid;
    logic       start;
    logic       cancel;
    logic       tick;
    logic       timer_zero;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       loadn, en, running, done;

    int total;
    int bad;
    int msec;

    keypad_loader #(.NDIG(4)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .key        (key),
        .key_valid  (key_valid),
        .start      (start),
        .cancel     (cancel),
        .tick       (tick),
        .timer_zero (timer_zero),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .loadn      (loadn),
        .en         (en),
        .running    (running),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter chain model: remaining time in seconds
    always @(posedge clk) begin
        if (!loadn)
            msec <= int'(min_tens) * 600 + int'(min_ones) * 60 + int'(sec_tens) * 10 + int'(sec_ones);
        else if (en)
            msec <= msec - 1;
    end
    assign timer_zero = (msec == 0);

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] disp();
        return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key = k;
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; msec = 0;
        clrn = 1'b0; key = '0; key_valid = 1'b0;
        start = 1'b0; cancel = 1'b0; tick = 1'b0;
        #12;
        check("rst_disp", disp(), 32'h0000);
        check("rst_loadn", 32'(loadn), 32'd1);
        check("rst_en", 32'(en), 32'd0);
        check("rst_run", 32'(running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        cyc();
        clrn = 1'b1;
        cyc();

        // Code above 9 is ignored in IDLE
        key = 4'd12; key_valid = 1'b1; cyc(); key_valid = 1'b0;
        check("idle_badkey", disp(), 32'h0000);

        // Keys 1,3,0 then start -> 01:30
        press(4'd1);
        check("key1", disp(), 32'h0001);
        press(4'd3);
        press(4'd0);
        check("key130", disp(), 32'h0130);
        do_start();
        check("load_loadn", 32'(loadn), 32'd0);
        check("load_run", 32'(running), 32'd0);
        tick = 1'b1; #1;
        check("load_tick_en", 32'(en), 32'd0);
        cyc();
        tick = 1'b0; #1;
        check("run_loadn", 32'(loadn), 32'd1);
        check("run_running", 32'(running), 32'd1);
        check("run_disp", disp(), 32'h0130);
        check("run_notick_en", 32'(en), 32'd0);
        tick = 1'b1; #1;
        check("run_tick_en", 32'(en), 32'd1);
        cyc();
        tick = 1'b0;

        // Pause, resume without reload, cancel twice
        do_cancel();
        check("pause_run", 32'(running), 32'd0);
        tick = 1'b1; #1;
        check("pause_en", 32'(en), 32'd0);
        cyc();
        tick = 1'b0;
        do_start();
        check("resume_run", 32'(running), 32'd1);
        check("resume_loadn", 32'(loadn), 32'd1);
        tick = 1'b1; #1;
        check("resume_en", 32'(en), 32'd1);
        tick = 1'b0; #1;
        do_cancel();
        do_cancel();
        check("cancel2_disp", disp(), 32'h0000);
        check("cancel2_run", 32'(running), 32'd0);

        // sec_tens = 9 rejects start; still in ENTRY afterwards
        press(4'd9);
        press(4'd9);
        do_start();
        check("rej99_loadn", 32'(loadn), 32'd1);
        press(4'd1);
        check("rej99_entry", disp(), 32'h0991);
        do_cancel();

        // All-zero entry rejects start
        press(4'd0);
        do_start();
        check("rej00_loadn", 32'(loadn), 32'd1);
        do_cancel();

        // Fifth key ignored
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check("fifth_key", disp(), 32'h1234);
        do_cancel();

        // 00:02 with three ticks
        press(4'd2);
        do_start();
        check("z_loadn", 32'(loadn), 32'd0);
        cyc();
        check("z_running", 32'(running), 32'd1);
        tick = 1'b1; #1;
        check("z_en1", 32'(en), 32'd1);
        cyc();
        #1;
        check("z_en2", 32'(en), 32'd1);
        cyc();
        #1;
        check("z_en3", 32'(en), 32'd0);
        check("z_done_early", 32'(done), 32'd0);
        cyc();
        tick = 1'b0;
        check("z_done", 32'(done), 32'd1);
        check("z_running_fall", 32'(running), 32'd0);
        check("z_disp", disp(), 32'h0000);
        cyc();
        check("z_done_once", 32'(done), 32'd0);

        // start + cancel together in ENTRY -> IDLE
        press(4'd1); press(4'd2);
        start = 1'b1; cancel = 1'b1; cyc(); start = 1'b0; cancel = 1'b0;
        check("sc_disp", disp(), 32'h0000);
        check("sc_loadn", 32'(loadn), 32'd1);
        press(4'd5);
        check("sc_idle", disp(), 32'h0005);
        do_cancel();

        // key with start: key dropped, start on pre-shift value 00:01
        press(4'd1);
        key = 4'd7; key_valid = 1'b1; start = 1'b1;
        cyc();
        key_valid = 1'b0; start = 1'b0;
        check("ks_loadn", 32'(loadn), 32'd0);
        check("ks_disp", disp(), 32'h0001);
        cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        // timer_zero now high; cancel in the same cycle
        cancel = 1'b1; tick = 1'b1; #1;
        check("tzc_en", 32'(en), 32'd0);
        cyc();
        cancel = 1'b0; tick = 1'b0;
        check("tzc_done", 32'(done), 32'd1);
        check("tzc_running", 32'(running), 32'd0);
        cyc();
        check("tzc_done_once", 32'(done), 32'd0);
        press(4'd3);
        check("tzc_idle", disp(), 32'h0003);
        do_cancel();

        // Reset mid-RUN during a tick
        press(4'd4);
        do_start();
        cyc();
        tick = 1'b1; #1;
        check("mr_en_pre", 32'(en), 32'd1);
        clrn = 1'b0; #1;
        check("mr_en", 32'(en), 32'd0);
        check("mr_loadn", 32'(loadn), 32'd1);
        check("mr_run", 32'(running), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_disp", disp(), 32'h0000);
        tick = 1'b0;
        cyc();
        clrn = 1'b1;
        cyc();
        check("mr_done_after", 32'(done), 32'd0);
        check("mr_run_after", 32'(running), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_loader.md
# keypad_loader

Front-end controller for the microwave timer. Collects BCD digits from the keypad into an MM:SS entry register and drives the parallel-load interface of the timer digit counters: data nibbles and an active-low `loadn` pulse. It then gates the 1 Hz count enable into the counter chain, supports pause/resume/cancel, and reports completion. It sits between the keypad decoder and the down-counting digit chain.

## Interface
Parameters:
- `NDIG`, 4, number of entry digits (MM:SS). Fixed at 4. Other values are unsupported.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `clrn`  in  1  reset, asynchronous, active-low
- `key`  in  4  BCD digit from keypad. Codes 10–15 are ignored.
- `key_valid`  in  1  one-cycle strobe qualifying `key`
- `start`  in  1  one-cycle strobe: start or resume
- `cancel`  in  1  one-cycle strobe: pause or clear
- `tick`  in  1  one-cycle 1 Hz pulse
- `timer_zero`  in  1  AND of all counter `zero` flags
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`  out  4 each  load data to the counters
- `loadn`  out  1  active-low parallel-load strobe to the counters
- `en`  out  1  count enable to the least-significant counter
- `running`  out  1  high in RUN
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ENTRY, LOAD, RUN, PAUSE.
- Entry register: 4 nibbles plus a digit count `cnt` (0–4).
- **IDLE**
  - A valid key (`key_valid` with `key` ≤ 9) sets `sec_ones` to `key`, sets `cnt` to 1, and goes to ENTRY.
  - `start` and `cancel` are ignored.
- **ENTRY**
  - Each valid key with `cnt` < 4 shifts the register left: `min_tens`←`min_ones`←`sec_tens`←`sec_ones`←`key`. `cnt` increments.
  - Keys with `cnt` = 4 are ignored.
  - `start` is accepted only if `sec_tens` ≤ 5 and the register is not all-zero. Then go to LOAD. Otherwise `start` is rejected and the state stays ENTRY.
  - `cancel` clears the register and `cnt`, then goes to IDLE.
- **LOAD**
  - Lasts exactly one cycle. `loadn` = 0 and `en` = 0. Data nibbles are stable.
  - Unconditionally goes to RUN. `start`, `cancel`, and keys are ignored.
- **RUN**
  - `en` = `tick` & ~`timer_zero` (combinational).
  - If `timer_zero` = 1: pulse `done` for one cycle, clear the register and `cnt`, and go to IDLE.
  - Otherwise, `cancel` goes to PAUSE.
  - `start` and keys are ignored.
- **PAUSE**
  - `en` = 0.
  - `start` goes to RUN with no reload; the counters keep their value.
  - `cancel` clears the register and `cnt`, then goes to IDLE.
  - Keys are ignored.
- Simultaneous events:
  - `cancel` has priority over `start` in every state.
  - A key with `start` in ENTRY: `start` is evaluated on the pre-shift register, and the key is dropped.
  - `timer_zero` has priority over `cancel` in RUN.
- `en` is never asserted while `timer_zero` = 1. This prevents the mod-6/mod-10 counters from wrapping past 00:00.
- Data outputs always show the entry register. They are held constant from LOAD until the return to IDLE.

## Timing
- Reset (`clrn` low, asynchronous): state IDLE; all nibbles 0; `cnt` 0; `loadn` 1; `en` 0; `running` 0; `done` 0. Reset mid-RUN drops `en` immediately, with no `done`.
- `loadn`, `running`, `done` are registered. `en` is combinational from state, `tick`, and `timer_zero`.
- Key latency: a digit strobed at edge N appears on `sec_ones` after edge N.
- Start latency: `start` sampled at edge N gives `loadn` = 0 during cycle N+1 (the counters load at edge N+1). `running` = 1 from edge N+1 through the RUN state. `timer_zero` reflects the loaded value from cycle N+2.
- The earliest `en` is the first `tick` in cycle N+2 or later. A `tick` during LOAD is dropped.
- `done` is asserted for the cycle after the edge that samples RUN with `timer_zero` = 1. `running` falls on the same edge.
- PAUSE→RUN: `en` can be asserted in the first cycle after the edge that samples `start`.

## Test plan
- Reset, then keys 1,3,0 and `start` → nibbles 0,1,3,0 (`min_tens`..`sec_ones`); `loadn` low for exactly 1 cycle; `running` rises; `en` pulses only on `tick`.
- Keys 9,9 (sec_tens = 9) then `start` → no `loadn` pulse; state stays ENTRY. A 5th key after 1,2,3,4 is ignored (register reads 12:34).
- Load 00:02 with the counter model; issue 3 ticks → 2 `en` pulses; the third `tick` gives `en` = 0; `done` is high for 1 cycle; `running` falls; nibbles return to 0.
- RUN, `cancel` → PAUSE; a `tick` there gives `en` = 0. `start` → RUN with no `loadn`. `cancel` twice → IDLE with a cleared register.
- `start` and `cancel` in the same cycle in ENTRY → IDLE; `cancel` in the same cycle `timer_zero` rises in RUN → `done` pulse, IDLE.
- Assert `clrn` low mid-RUN during a `tick` → `en` falls immediately; all outputs at reset values; no `done`.
